// File: rtl/trigger_pkg.sv
// Shared types and constants for the per-channel trigger/acquisition stage.
package trigger_pkg;

  localparam int unsigned SAMPLE_WIDTH   = 16;
  localparam int unsigned BASELINE_WIDTH = 13;

  typedef enum logic [1:0] {
    ACQ_OFF       = 2'd0,
    ACQ_THRESHOLD = 2'd1,
    ACQ_FORCED    = 2'd2,
    ACQ_RESERVED  = 2'd3
  } acq_mode_e;

  localparam int unsigned TRIG_RISING_BIT  = 0;
  localparam int unsigned TRIG_FALLING_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRIG  = 2'd2,
    POST  = 2'd3
  } state_e;

  // Baseline-corrected sample: 17-bit difference saturated back to 16 bits.
  function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sub(
    input logic signed [SAMPLE_WIDTH-1:0]   sample,
    input logic signed [BASELINE_WIDTH-1:0] baseline
  );
    logic [SAMPLE_WIDTH:0] diff;
    diff = {sample[SAMPLE_WIDTH-1], sample}
         - {{(SAMPLE_WIDTH + 1 - BASELINE_WIDTH){baseline[BASELINE_WIDTH-1]}}, baseline};
    if (diff[SAMPLE_WIDTH] != diff[SAMPLE_WIDTH-1]) begin
      sat_sub = diff[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else begin
      sat_sub = diff[SAMPLE_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/trigger_acquisition_unit_if.sv
// Config, sample and framed-output bundle of the trigger/acquisition stage.
// TIMESTAMP exists only when TRIGGER_TIMESTAMP_EN is defined.
interface trigger_acquisition_unit_if #(
  parameter int unsigned MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int unsigned MAX_POST_ACQUISITION_LENGTH = 2
);
  import trigger_pkg::*;

  localparam int unsigned PRE_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1;
  localparam int unsigned POST_W = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1;

  logic                             SET_CONFIG;
  logic                             STOP;
  logic [1:0]                       ACQUIRE_MODE;
  logic [3:0]                       TRIGGER_TYPE;
  logic signed [SAMPLE_WIDTH-1:0]   RISING_EDGE_THRESHOLD;
  logic signed [SAMPLE_WIDTH-1:0]   FALLING_EDGE_THRESHOLD;
  logic signed [BASELINE_WIDTH-1:0] H_GAIN_BASELINE;
  logic [PRE_W-1:0]                 PRE_ACQUISITION_LENGTH;
  logic [POST_W-1:0]                POST_ACQUISITION_LENGTH;
  logic [15:0]                      MAX_TRIGGER_LENGTH;
  logic signed [SAMPLE_WIDTH-1:0]   SAMPLE_IN;
  logic                             SAMPLE_VALID;
  logic signed [SAMPLE_WIDTH-1:0]   DATA_OUT;
  logic                             DATA_VALID;
  logic                             FRAME_START;
  logic                             FRAME_END;
  logic                             BUSY;
`ifdef TRIGGER_TIMESTAMP_EN
  logic [47:0]                      TIMESTAMP;
`endif

  modport master (
`ifdef TRIGGER_TIMESTAMP_EN
    input  TIMESTAMP,
`endif
    output SET_CONFIG, STOP, ACQUIRE_MODE, TRIGGER_TYPE, RISING_EDGE_THRESHOLD,
           FALLING_EDGE_THRESHOLD, H_GAIN_BASELINE, PRE_ACQUISITION_LENGTH,
           POST_ACQUISITION_LENGTH, MAX_TRIGGER_LENGTH, SAMPLE_IN, SAMPLE_VALID,
    input  DATA_OUT, DATA_VALID, FRAME_START, FRAME_END, BUSY
  );

  modport slave (
`ifdef TRIGGER_TIMESTAMP_EN
    output TIMESTAMP,
`endif
    input  SET_CONFIG, STOP, ACQUIRE_MODE, TRIGGER_TYPE, RISING_EDGE_THRESHOLD,
           FALLING_EDGE_THRESHOLD, H_GAIN_BASELINE, PRE_ACQUISITION_LENGTH,
           POST_ACQUISITION_LENGTH, MAX_TRIGGER_LENGTH, SAMPLE_IN, SAMPLE_VALID,
    output DATA_OUT, DATA_VALID, FRAME_START, FRAME_END, BUSY
  );

endinterface

// File: rtl/pre_acquisition_buffer.sv
// Valid-gated sample delay line with a runtime tap; tap 0 passes the input straight through.
module pre_acquisition_buffer #(
  parameter int unsigned MAX_DEPTH = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TAP_W     = $clog2(MAX_DEPTH) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic [TAP_W-1:0]        i_tap,
  output logic signed [WIDTH-1:0] o_data
);

  logic signed [WIDTH-1:0] r_line [MAX_DEPTH];
  logic signed [WIDTH-1:0] r_data;
  logic signed [WIDTH-1:0] w_tap;

  // r_line[k] holds the sample k+1 valid strobes older than i_data.
  always_comb begin
    w_tap = i_data;
    for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
      if (i_tap == TAP_W'(k)) w_tap = r_line[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < MAX_DEPTH; k++) r_line[k] <= '0;
      r_data <= '0;
    end else if (i_valid) begin
      r_line[0] <= i_data;
      for (int unsigned k = 1; k < MAX_DEPTH; k++) r_line[k] <= r_line[k-1];
      r_data <= w_tap;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/trigger_acquisition_unit.sv
// Per-channel baseline correction, threshold trigger and pre/post window framing.
// Optional TRIGGER_TIMESTAMP_EN adds a 48-bit trigger timestamp output.
module trigger_acquisition_unit
  import trigger_pkg::*;
#(
  parameter int unsigned MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int unsigned MAX_POST_ACQUISITION_LENGTH = 2
) (
  input logic ACLK,
  input logic ARESET,
  trigger_acquisition_unit_if.slave bus_if
);

  localparam int unsigned PRE_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1;
  localparam int unsigned POST_W = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1;
  localparam int unsigned REM_W  =
    $clog2(MAX_PRE_ACQUISITION_LENGTH + MAX_POST_ACQUISITION_LENGTH + 1) + 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(MAX_PRE_ACQUISITION_LENGTH);
  localparam logic [POST_W-1:0] POST_MAX = POST_W'(MAX_POST_ACQUISITION_LENGTH);

  state_e                           r_state, w_state_next;
  acq_mode_e                        r_mode, w_mode_in;
  logic                             r_rise_en, r_fall_en;
  logic signed [SAMPLE_WIDTH-1:0]   r_rising, r_falling;
  logic signed [BASELINE_WIDTH-1:0] r_baseline;
  logic [PRE_W-1:0]                 r_pre, r_fill, w_pre_clamped;
  logic [POST_W-1:0]                r_post, w_post_clamped;
  logic [15:0]                      r_max_len, r_trig_cnt, w_trig_cnt;
  logic [REM_W-1:0]                 r_remaining, w_pp_sum;
  logic signed [SAMPLE_WIDTH-1:0]   r_cs, r_prev_cs;
  logic                             r_cs_valid;
  logic                             r_data_valid, r_frame_start, r_frame_end;
  logic w_cfg_load, w_arm_mode, w_start, w_in_trig, w_trig_end, w_post_last;
  logic w_gate, w_frame_end, w_rise_hit, w_fall_hit, w_len_hit;
  logic w_unused_type;

  assign w_unused_type  = ^bus_if.TRIGGER_TYPE[3:2];
  assign w_mode_in      = acq_mode_e'(bus_if.ACQUIRE_MODE);
  assign w_arm_mode     = (w_mode_in == ACQ_THRESHOLD) || (w_mode_in == ACQ_FORCED);
  assign w_cfg_load     = bus_if.SET_CONFIG && !bus_if.STOP && (r_state == IDLE);
  assign w_pre_clamped  = (bus_if.PRE_ACQUISITION_LENGTH > PRE_MAX) ? PRE_MAX
                                                                     : bus_if.PRE_ACQUISITION_LENGTH;
  assign w_post_clamped = (bus_if.POST_ACQUISITION_LENGTH > POST_MAX) ? POST_MAX
                                                                       : bus_if.POST_ACQUISITION_LENGTH;
  assign w_pp_sum       = REM_W'(r_pre) + REM_W'(r_post);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_mode     <= ACQ_OFF;
      r_rise_en  <= 1'b0;
      r_fall_en  <= 1'b0;
      r_rising   <= '0;
      r_falling  <= '0;
      r_baseline <= '0;
      r_pre      <= '0;
      r_post     <= '0;
      r_max_len  <= '0;
    end else if (w_cfg_load) begin
      r_mode     <= w_mode_in;
      r_rise_en  <= bus_if.TRIGGER_TYPE[TRIG_RISING_BIT];
      r_fall_en  <= bus_if.TRIGGER_TYPE[TRIG_FALLING_BIT];
      r_rising   <= bus_if.RISING_EDGE_THRESHOLD;
      r_falling  <= bus_if.FALLING_EDGE_THRESHOLD;
      r_baseline <= bus_if.H_GAIN_BASELINE;
      r_pre      <= w_pre_clamped;
      r_post     <= w_post_clamped;
      r_max_len  <= bus_if.MAX_TRIGGER_LENGTH;
    end
  end

  // Stage 1: corrected sample; the previous valid cs feeds the rising-crossing test.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cs       <= '0;
      r_cs_valid <= 1'b0;
      r_prev_cs  <= '0;
    end else begin
      r_cs_valid <= bus_if.SAMPLE_VALID;
      if (bus_if.SAMPLE_VALID) r_cs <= sat_sub(bus_if.SAMPLE_IN, r_baseline);
      if (r_cs_valid) r_prev_cs <= r_cs;
    end
  end

  pre_acquisition_buffer #(
    .MAX_DEPTH (MAX_PRE_ACQUISITION_LENGTH),
    .WIDTH     (SAMPLE_WIDTH),
    .TAP_W     (PRE_W)
  ) u_pre_buf (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_valid (r_cs_valid),
    .i_data  (r_cs),
    .i_tap   (r_pre),
    .o_data  (bus_if.DATA_OUT)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus_if.STOP) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_cfg_load && w_arm_mode) w_state_next = ARMED;
        ARMED: begin
          if (w_start) begin
            if (!w_trig_end)          w_state_next = TRIG;
            else if (w_pp_sum != '0)  w_state_next = POST;
          end
        end
        TRIG:    if (w_trig_end) w_state_next = (w_pp_sum == '0) ? ARMED : POST;
        POST:    if (w_post_last) w_state_next = ARMED;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Decode of the sample currently in stage 1; gating lands on its stage-2 tap output.
  always_comb begin
    w_rise_hit  = r_rise_en && (r_cs >= r_rising) && (r_prev_cs < r_rising);
    w_start     = r_cs_valid && (r_state == ARMED) && (r_fill >= r_pre)
               && ((r_mode == ACQ_FORCED) || ((r_mode == ACQ_THRESHOLD) && w_rise_hit));
    w_in_trig   = w_start || (r_cs_valid && (r_state == TRIG));
    w_trig_cnt  = (r_state == TRIG) ? r_trig_cnt + 16'd1 : 16'd1;
    w_fall_hit  = r_fall_en && (r_cs < r_falling);
    w_len_hit   = (r_max_len != '0) && (w_trig_cnt == r_max_len);
    w_trig_end  = w_in_trig && (w_fall_hit || w_len_hit);
    w_post_last = r_cs_valid && (r_state == POST) && (r_remaining == REM_W'(1));
    w_gate      = w_in_trig || (r_cs_valid && (r_state == POST));
    w_frame_end = (w_trig_end && (w_pp_sum == '0)) || w_post_last;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_fill      <= '0;
      r_trig_cnt  <= '0;
      r_remaining <= '0;
    end else begin
      if (w_cfg_load && w_arm_mode) begin
        r_fill <= '0;
      end else if (r_cs_valid && (r_state != IDLE) && (r_fill < r_pre)) begin
        r_fill <= r_fill + PRE_W'(1);
      end
      if (w_in_trig) r_trig_cnt <= w_trig_cnt;
      if (w_trig_end) begin
        r_remaining <= w_pp_sum;
      end else if (r_cs_valid && (r_state == POST)) begin
        r_remaining <= r_remaining - REM_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end else begin
      r_data_valid  <= !bus_if.STOP && w_gate;
      r_frame_start <= !bus_if.STOP && w_start;
      r_frame_end   <= !bus_if.STOP && w_frame_end;
    end
  end

  assign bus_if.DATA_VALID  = r_data_valid;
  assign bus_if.FRAME_START = r_frame_start;
  assign bus_if.FRAME_END   = r_frame_end;
  assign bus_if.BUSY        = (r_state != IDLE);

`ifdef TRIGGER_TIMESTAMP_EN
  logic [47:0] r_ts_counter, r_timestamp;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ts_counter <= '0;
      r_timestamp  <= '0;
    end else begin
      r_ts_counter <= r_ts_counter + 48'd1;
      if (w_start && !bus_if.STOP) r_timestamp <= r_ts_counter;
    end
  end

  assign bus_if.TIMESTAMP = r_timestamp;
`endif

endmodule
